icache_dm: RTL

ICACHE_DM -- requirements
Module: icache_dm

---
 rtl/icache_dm.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/icache_dm.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | icache_dm : direct-mapped instruction cache, full-line responses         |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+

package icache_dm_pkg;
  localparam int CL_SZ_WORDS = 4;
  localparam int ID_W        = 8;
  localparam int ADDR_W      = 32;
  localparam int LINE_W      = CL_SZ_WORDS * 32;

  typedef struct packed {
    logic              valid;
    logic [ID_W-1:0]   id;
    logic [ADDR_W-1:0] addr;
  } t_mem_req;

  typedef struct packed {
    logic              valid;
    logic [ID_W-1:0]   id;
    logic [LINE_W-1:0] data;
  } t_mem_rsp;
endpackage

module icache_dm
  import icache_dm_pkg::*;
#(
  parameter int              NUM_SETS = 64,
  parameter logic [ID_W-1:0] MEM_ID   = '0
) (
  input  logic        clk,
  input  logic        reset,
  input  t_mem_req    fb_ic_req_nnn,
  output logic        ic_fb_req_rdy_nnn,
  output t_mem_rsp    ic_fb_rsp_nnn,
  output t_mem_req    ic_mem_req_nnn,
  input  t_mem_rsp    mem_ic_rsp_nnn,
  input  logic        flush,
  output logic [31:0] hit_cnt,
  output logic [31:0] miss_cnt
);
  localparam int OFF_W = $clog2(CL_SZ_WORDS * 4);
  localparam int IDX_W = $clog2(NUM_SETS);
  localparam int TAG_W = ADDR_W - OFF_W - IDX_W;
  localparam logic [ADDR_W-1:0] OFF_MASK = ADDR_W'((1 << OFF_W) - 1);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_LOOKUP    = 3'd1,
    S_MISS_REQ  = 3'd2,
    S_MISS_WAIT = 3'd3,
    S_RESP      = 3'd4
  } state_t;

  state_t state, state_nxt;

  logic [NUM_SETS-1:0] valid_bits;
  logic [TAG_W-1:0]    tag_mem  [NUM_SETS];
  logic [LINE_W-1:0]   data_mem [NUM_SETS];
  logic                flush_pend;
  logic [ID_W-1:0]     cap_id;
  logic [ADDR_W-1:0]   cap_addr;

  logic [IDX_W-1:0] cap_idx;
  logic [TAG_W-1:0] cap_tag;
  logic             hit;
  logic             accept;
  logic             fill_ok;
  logic             flush_now;
  logic             rsp_valid;
  logic             mem_valid;

  assign cap_idx   = cap_addr[OFF_W +: IDX_W];
  assign cap_tag   = cap_addr[ADDR_W-1 -: TAG_W];
  assign hit       = valid_bits[cap_idx] && (tag_mem[cap_idx] == cap_tag);
  assign ic_fb_req_rdy_nnn = reset && (state == S_IDLE) && !flush && !flush_pend;
  assign accept    = ic_fb_req_rdy_nnn && fb_ic_req_nnn.valid;
  assign fill_ok   = reset && (state == S_MISS_WAIT) && mem_ic_rsp_nnn.valid &&
                     (mem_ic_rsp_nnn.id == MEM_ID);
  // A pending flush is only applied once the in-flight request has drained.
  assign flush_now = (state == S_IDLE) && (flush || flush_pend);

  always_comb begin
    state_nxt = state;
    rsp_valid = 1'b0;
    mem_valid = 1'b0;
    case (state)
      S_IDLE:      if (accept) state_nxt = S_LOOKUP;
      S_LOOKUP: begin
        if (hit) begin
          rsp_valid = 1'b1;
          state_nxt = S_IDLE;
        end else begin
          state_nxt = S_MISS_REQ;
        end
      end
      S_MISS_REQ: begin
        mem_valid = 1'b1;
        state_nxt = S_MISS_WAIT;
      end
      S_MISS_WAIT: if (fill_ok) state_nxt = S_RESP;
      S_RESP: begin
        rsp_valid = 1'b1;
        state_nxt = S_IDLE;
      end
      default:     state_nxt = S_IDLE;
    endcase
  end

  assign ic_fb_rsp_nnn  = {rsp_valid && reset, cap_id, data_mem[cap_idx]};
  assign ic_mem_req_nnn = {mem_valid && reset, MEM_ID, cap_addr & ~OFF_MASK};

  always_ff @(posedge clk) begin
    if (!reset) begin
      state      <= S_IDLE;
      valid_bits <= '0;
      flush_pend <= 1'b0;
      hit_cnt    <= '0;
      miss_cnt   <= '0;
    end else begin
      state <= state_nxt;
      if (state == S_LOOKUP) begin
        if (hit) hit_cnt  <= hit_cnt + 32'd1;
        else     miss_cnt <= miss_cnt + 32'd1;
      end
      if (flush_now) begin
        valid_bits <= '0;
        flush_pend <= 1'b0;
      end else begin
        if (flush)   flush_pend          <= 1'b1;
        if (fill_ok) valid_bits[cap_idx] <= 1'b1;
      end
    end
  end

  // Capture registers and line storage carry no reset.
  always_ff @(posedge clk) begin
    if (accept) begin
      cap_id   <= fb_ic_req_nnn.id;
      cap_addr <= fb_ic_req_nnn.addr;
    end
    if (fill_ok) begin
      tag_mem[cap_idx]  <= cap_tag;
      data_mem[cap_idx] <= mem_ic_rsp_nnn.data;
    end
  end

endmodule
`default_nettype wire
